// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ
// requesters; stages one registered write per cycle and flags the in-flight register.
module rf_write_arbiter #(
  parameter int NREQ = 2,
  parameter int DW   = 16,
  parameter int AW   = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [AW*NREQ-1:0] req_dr,
  input  logic [DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               hold,
  output logic               rf_we,
  output logic [AW-1:0]      rf_dr,
  output logic [DW-1:0]      rf_data,
  output logic [7:0]         pend_mask,
  output logic [1:0]         grant_id,
  output logic [15:0]        wr_count
);

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_dr_q, rf_dr_d;
  logic [DW-1:0]   rf_data_q, rf_data_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [15:0]     wr_count_q, wr_count_d;

  logic            found_s;
  logic [1:0]      gnt_idx_s;
  logic [1:0]      gnt_next_s;
  logic [AW-1:0]   sel_dr_s;
  logic [DW-1:0]   sel_data_s;
  int              scan_idx;

  // Rotating-priority scan: visit requesters ptr, ptr+1, ... and take the first valid one.
  always_comb begin
    found_s    = 1'b0;
    gnt_idx_s  = 2'd0;
    gnt_next_s = 2'd0;
    sel_dr_s   = '0;
    sel_data_s = '0;
    scan_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NREQ) begin
        scan_idx = scan_idx - NREQ;
      end else begin
        scan_idx = scan_idx;
      end
      for (int j = 0; j < NREQ; j++) begin
        if (!found_s && !hold && !rst && req_valid[j] && (j == scan_idx)) begin
          found_s    = 1'b1;
          gnt_idx_s  = 2'(j);
          gnt_next_s = (j + 1 >= NREQ) ? 2'd0 : 2'(j + 1);
          sel_dr_s   = req_dr[AW*j +: AW];
          sel_data_s = req_data[DW*j +: DW];
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // One-hot ready plus next-state for the staged write, pointer and counter.
  always_comb begin
    req_ready  = '0;
    rf_we_d    = found_s;
    rf_dr_d    = rf_dr_q;
    rf_data_d  = rf_data_q;
    grant_id_d = grant_id_q;
    ptr_d      = ptr_q;
    wr_count_d = wr_count_q;
    for (int j = 0; j < NREQ; j++) begin
      req_ready[j] = found_s && (gnt_idx_s == 2'(j));
    end
    if (found_s) begin
      rf_dr_d    = sel_dr_s;
      rf_data_d  = sel_data_s;
      grant_id_d = gnt_idx_s;
      ptr_d      = gnt_next_s;
      if (wr_count_q != 16'hFFFF) begin
        wr_count_d = wr_count_q + 16'd1;
      end else begin
        wr_count_d = wr_count_q;
      end
    end else begin
      rf_we_d = 1'b0;
    end
  end

  // Staged write port and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_q    <= 1'b0;
      rf_dr_q    <= '0;
      rf_data_q  <= '0;
      grant_id_q <= 2'd0;
      ptr_q      <= 2'd0;
      wr_count_q <= 16'd0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_dr_q    <= rf_dr_d;
      rf_data_q  <= rf_data_d;
      grant_id_q <= grant_id_d;
      ptr_q      <= ptr_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_dr     = rf_dr_q;
  assign rf_data   = rf_data_q;
  assign grant_id  = grant_id_q;
  assign wr_count  = wr_count_q;
  assign pend_mask = rf_we_q ? (8'h01 << rf_dr_q) : 8'h00;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with NREQ=2 and a small 8x16 register file model.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [5:0]  req_dr;
  logic [31:0] req_data;
  logic [1:0]  req_ready;
  logic        hold;
  logic        rf_we;
  logic [2:0]  rf_dr;
  logic [15:0] rf_data;
  logic [7:0]  pend_mask;
  logic [1:0]  grant_id;
  logic [15:0] wr_count;
  logic [15:0] regs [0:7];

  int checks;
  int errors;

  rf_write_arbiter #(.NREQ(2), .DW(16), .AW(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dr(req_dr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold),
    .rf_we(rf_we), .rf_dr(rf_dr), .rf_data(rf_data),
    .pend_mask(pend_mask), .grant_id(grant_id), .wr_count(wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file fed by the arbiter's write port
  always_ff @(posedge clk) begin
    if (rf_we) regs[rf_dr] <= rf_data;
  end

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0; req_valid = 2'b11;
    req_dr = 6'd0; req_data = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", req_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", rf_we); end
    checks++; if (pend_mask !== 8'h00) begin errors++; $display("FAIL reset_pend got %h want 00", pend_mask); end
    checks++; if (wr_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h want 0000", wr_count); end
    checks++; if (grant_id !== 2'd0 || rf_dr !== 3'd0 || rf_data !== 16'h0000) begin
      errors++; $display("FAIL reset_regs got id=%0d dr=%0d data=%h want 0 0 0000", grant_id, rf_dr, rf_data); end
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req_valid = 2'b01; req_dr[2:0] = 3'd3; req_data[15:0] = 16'hBEEF;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (rf_we !== 1'b1 || rf_dr !== 3'd3 || rf_data !== 16'hBEEF) begin
      errors++; $display("FAIL single_write got we=%b dr=%0d data=%h want 1 3 beef", rf_we, rf_dr, rf_data); end
    checks++; if (pend_mask !== 8'h08) begin errors++; $display("FAIL single_pend got %h want 08", pend_mask); end
    checks++; if (wr_count !== 16'd1 || grant_id !== 2'd0) begin
      errors++; $display("FAIL single_count got cnt=%0d id=%0d want 1 0", wr_count, grant_id); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || pend_mask !== 8'h00 || rf_dr !== 3'd3) begin
      errors++; $display("FAIL single_idle got we=%b pend=%h dr=%0d want 0 00 3", rf_we, pend_mask, rf_dr); end
    checks++; if (regs[3] !== 16'hBEEF) begin errors++; $display("FAIL single_rf got %h want beef", regs[3]); end
  endtask

  // Pointer sits at 1 after the single r0 write, so the alternation starts at r1.
  task automatic test_contention();
    logic [1:0] exp_rdy [0:3];
    logic [2:0] exp_dr  [0:3];
    exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10; exp_rdy[3] = 2'b01;
    exp_dr[0]  = 3'd2;  exp_dr[1]  = 3'd1;  exp_dr[2]  = 3'd2;  exp_dr[3]  = 3'd1;
    @(negedge clk);
    req_dr = {3'd2, 3'd1}; req_data = {16'hB0B0, 16'hA0A0};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== exp_rdy[k]) begin
        errors++; $display("FAIL cont_ready[%0d] got %b want %b", k, req_ready, exp_rdy[k]); end
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_dr !== exp_dr[k] || grant_id !== ((k % 2 == 0) ? 2'd1 : 2'd0)) begin
        errors++; $display("FAIL cont_write[%0d] got we=%b dr=%0d id=%0d want dr=%0d", k, rf_we, rf_dr, grant_id, exp_dr[k]); end
    end
    req_valid = 2'b00;
    checks++; if (wr_count !== 16'd5) begin errors++; $display("FAIL cont_count got %0d want 5", wr_count); end
    @(negedge clk);
    checks++; if (regs[1] !== 16'hA0A0 || regs[2] !== 16'hB0B0) begin
      errors++; $display("FAIL cont_rf got r1=%h r2=%h want a0a0 b0b0", regs[1], regs[2]); end
  endtask

  task automatic test_hold();
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL hold_pre got %b want 10", req_ready); end
    @(negedge clk);
    hold = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL hold_ready got %b want 00", req_ready); end
    checks++; if (rf_we !== 1'b1 || rf_dr !== 3'd2) begin
      errors++; $display("FAIL hold_drain got we=%b dr=%0d want 1 2", rf_we, rf_dr); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (rf_we !== 1'b0 || req_ready !== 2'b00 || wr_count !== 16'd6) begin
        errors++; $display("FAIL hold_frozen got we=%b rdy=%b cnt=%0d want 0 00 6", rf_we, req_ready, wr_count); end
    end
    hold = 1'b0;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL hold_resume got %b want 01", req_ready); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (rf_we !== 1'b1 || grant_id !== 2'd0 || rf_dr !== 3'd1 || wr_count !== 16'd7) begin
      errors++; $display("FAIL hold_after got we=%b id=%0d dr=%0d cnt=%0d want 1 0 1 7", rf_we, grant_id, rf_dr, wr_count); end
    // A requester that withdraws while held is never recorded
    hold = 1'b1; req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00; hold = 1'b0;
    @(negedge clk);
    checks++; if (wr_count !== 16'd7 || rf_we !== 1'b0) begin
      errors++; $display("FAIL drop_valid got cnt=%0d we=%b want 7 0", wr_count, rf_we); end
  endtask

  task automatic test_same_dest();
    req_dr = {3'd5, 3'd5}; req_data = {16'h0002, 16'h0001};
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b10;
    checks++; if (rf_data !== 16'h0001 || rf_dr !== 3'd5) begin
      errors++; $display("FAIL same_first got dr=%0d data=%h want 5 0001", rf_dr, rf_data); end
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (rf_data !== 16'h0002 || grant_id !== 2'd1 || pend_mask !== 8'h20) begin
      errors++; $display("FAIL same_second got data=%h id=%0d pend=%h want 0002 1 20", rf_data, grant_id, pend_mask); end
    @(negedge clk);
    checks++; if (regs[5] !== 16'h0002) begin errors++; $display("FAIL same_rf got %h want 0002", regs[5]); end
  endtask

  task automatic test_saturation();
    force dut.wr_count_q = 16'hFFFE;
    #1;
    release dut.wr_count_q;
    #1;
    checks++; if (wr_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preset got %h want fffe", wr_count); end
    req_dr[2:0] = 3'd6; req_data[15:0] = 16'h1234;
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (wr_count !== 16'hFFFF || rf_we !== 1'b1) begin
        errors++; $display("FAIL sat_count[%0d] got cnt=%h we=%b want ffff 1", k, wr_count, rf_we); end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0 || pend_mask !== 8'h00 || req_ready !== 2'b00 || wr_count !== 16'h0000) begin
      errors++; $display("FAIL async_rst got we=%b pend=%h rdy=%b cnt=%h want 0 00 00 0000", rf_we, pend_mask, req_ready, wr_count); end
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) regs[i] = 16'h0000;
    test_reset();
    test_single();
    test_contention();
    test_hold();
    test_same_dest();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
